// File: rtl/pong_graphics_if.sv
// Pixel-stream bundle between vga_sync and the Pong graphics stage.
// The master drives pixel timing and coordinates and receives the colour;
// the slave (graphics engine) does the opposite.
interface pong_graphics_if;
  logic       p_tick;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [11:0] vga_rgb;

  modport master (
    output p_tick,
    output video_on,
    output pixel_x,
    output pixel_y,
    input  vga_rgb
  );

  modport slave (
    input  p_tick,
    input  video_on,
    input  pixel_x,
    input  pixel_y,
    output vga_rgb
  );
endinterface

// File: rtl/pong_graphics.sv
// Pong pixel-stage graphics engine.
// Runs the once-per-frame game state (ball, paddle, hit counter, miss hold)
// during vertical blanking and renders a registered 12-bit RGB pixel from
// the current coordinates with priority ball > paddle > wall > background.
module pong_graphics (
  input  logic            clk,
  input  logic            rst_n,
  pong_graphics_if.slave  vid_if,
  input  logic [11:0]     sw_i,
  input  logic            btn_up_i,
  input  logic            btn_down_i,
  input  logic            btn_serve_i,
  output logic [7:0]      hits_o,
  output logic            miss_o
);

  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] BALL_SIZE = 10'd8;
  localparam logic [9:0] BALL_V    = 10'd2;
  localparam logic [9:0] PAD_H     = 10'd72;
  localparam logic [9:0] PAD_V     = 10'd4;
  localparam logic [9:0] WALL_X_L  = 10'd32;
  localparam logic [9:0] WALL_X_R  = 10'd35;
  localparam logic [9:0] PAD_X_L   = 10'd600;
  localparam logic [9:0] PAD_X_R   = 10'd603;
  localparam logic [5:0] HOLD_LAST = 6'd59;

  localparam logic [9:0] HOME_X    = 10'd316;
  localparam logic [9:0] HOME_Y    = 10'd236;
  localparam logic [9:0] PAD_HOME  = 10'd204;
  localparam logic [9:0] REFR_Y    = V_VIS + 10'd1;

  localparam logic [11:0] COLOR_BALL = 12'hF00;
  localparam logic [11:0] COLOR_PAD  = 12'h0F0;
  localparam logic [11:0] COLOR_WALL = 12'h00F;

  typedef enum logic [1:0] {
    S_WAIT,
    S_PLAY,
    S_MISS_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  ballX_q, ballX_d;
  logic [9:0]  ballY_q, ballY_d;
  logic        dxNeg_q, dxNeg_d;
  logic        dyNeg_q, dyNeg_d;
  logic [9:0]  padTop_q, padTop_d;
  logic [5:0]  holdCnt_q, holdCnt_d;
  logic [7:0]  hits_q, hits_d;
  logic        miss_q, miss_d;
  logic [11:0] rgb_q, rgb_d;

  logic        refrTick;
  logic [9:0]  ballRight;
  logic [9:0]  ballBottom;
  logic [9:0]  padBottom;
  logic        padHit;
  logic        ballOn;
  logic        padOn;
  logic        wallOn;

  // Frame tick once per frame, in vertical blanking, plus derived object edges
  always_comb begin
    refrTick   = vid_if.p_tick && (vid_if.pixel_x == 10'd0) && (vid_if.pixel_y == REFR_Y);
    ballRight  = ballX_q + BALL_SIZE - 10'd1;
    ballBottom = ballY_q + BALL_SIZE - 10'd1;
    padBottom  = padTop_q + PAD_H - 10'd1;
    padHit     = !dxNeg_q
              && (ballRight >= PAD_X_L) && (ballRight <= PAD_X_R)
              && (ballBottom >= padTop_q) && (ballY_q <= padBottom);
  end

  // Game state: paddle movement in every state, ball motion driven by the FSM
  always_comb begin
    state_d   = state_q;
    ballX_d   = ballX_q;
    ballY_d   = ballY_q;
    dxNeg_d   = dxNeg_q;
    dyNeg_d   = dyNeg_q;
    padTop_d  = padTop_q;
    holdCnt_d = holdCnt_q;
    hits_d    = hits_q;
    miss_d    = 1'b0;

    if (refrTick) begin
      if (btn_up_i && !btn_down_i && (padTop_q >= PAD_V)) begin
        padTop_d = padTop_q - PAD_V;
      end else if (btn_down_i && !btn_up_i && (padBottom <= V_VIS - 10'd1 - PAD_V)) begin
        padTop_d = padTop_q + PAD_V;
      end
    end

    case (state_q)
      S_WAIT: begin
        ballX_d = HOME_X;
        ballY_d = HOME_Y;
        dxNeg_d = 1'b0;
        dyNeg_d = 1'b0;
        if (refrTick && btn_serve_i) begin
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (refrTick) begin
          if (ballRight >= H_VIS - 10'd1) begin
            miss_d    = 1'b1;
            holdCnt_d = 6'd0;
            state_d   = S_MISS_HOLD;
          end else begin
            if (ballY_q <= 10'd1) begin
              dyNeg_d = 1'b0;
            end else if (ballBottom >= V_VIS - 10'd2) begin
              dyNeg_d = 1'b1;
            end
            if (ballX_q <= WALL_X_R) begin
              dxNeg_d = 1'b0;
            end else if (padHit) begin
              dxNeg_d = 1'b1;
              if (hits_q != 8'hFF) begin
                hits_d = hits_q + 8'd1;
              end
            end
            ballX_d = dxNeg_d ? (ballX_q - BALL_V) : (ballX_q + BALL_V);
            ballY_d = dyNeg_d ? (ballY_q - BALL_V) : (ballY_q + BALL_V);
          end
        end
      end

      S_MISS_HOLD: begin
        if (refrTick) begin
          if (holdCnt_q == HOLD_LAST) begin
            state_d = S_WAIT;
            ballX_d = HOME_X;
            ballY_d = HOME_Y;
            dxNeg_d = 1'b0;
            dyNeg_d = 1'b0;
          end else begin
            holdCnt_d = holdCnt_q + 6'd1;
          end
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // Pixel colour for the current coordinates, by object priority
  always_comb begin
    ballOn = (vid_if.pixel_x >= ballX_q) && (vid_if.pixel_x <= ballRight)
          && (vid_if.pixel_y >= ballY_q) && (vid_if.pixel_y <= ballBottom);
    padOn  = (vid_if.pixel_x >= PAD_X_L) && (vid_if.pixel_x <= PAD_X_R)
          && (vid_if.pixel_y >= padTop_q) && (vid_if.pixel_y <= padBottom);
    wallOn = (vid_if.pixel_x >= WALL_X_L) && (vid_if.pixel_x <= WALL_X_R);

    rgb_d = sw_i;
    if (!vid_if.video_on) begin
      rgb_d = 12'h000;
    end else if (ballOn) begin
      rgb_d = COLOR_BALL;
    end else if (padOn) begin
      rgb_d = COLOR_PAD;
    end else if (wallOn) begin
      rgb_d = COLOR_WALL;
    end
  end

  // State and output registers, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      ballX_q   <= HOME_X;
      ballY_q   <= HOME_Y;
      dxNeg_q   <= 1'b0;
      dyNeg_q   <= 1'b0;
      padTop_q  <= PAD_HOME;
      holdCnt_q <= 6'd0;
      hits_q    <= 8'd0;
      miss_q    <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      state_q   <= state_d;
      ballX_q   <= ballX_d;
      ballY_q   <= ballY_d;
      dxNeg_q   <= dxNeg_d;
      dyNeg_q   <= dyNeg_d;
      padTop_q  <= padTop_d;
      holdCnt_q <= holdCnt_d;
      hits_q    <= hits_d;
      miss_q    <= miss_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vid_if.vga_rgb = rgb_q;
  assign hits_o         = hits_q;
  assign miss_o         = miss_q;

endmodule
